// File: rtl/dewhiten_arbiter.sv
// ============================================================================
// Module  : dewhiten_arbiter
// Purpose : Round-robin frame arbiter sharing one PN9 dewhitener between two
//           demodulator bit streams, with gap/timeout/length abort and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dewhiten_arbiter #(
  parameter int START_TO  = 64,
  parameter int MAX_BYTES = 255,
  parameter int FLUSH_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch0_req,
  input  logic       ch1_req,
  input  logic       ch0_bit,
  input  logic       ch1_bit,
  input  logic       ch0_bit_valid,
  input  logic       ch1_bit_valid,
  output logic       ch0_gnt,
  output logic       ch1_gnt,
  output logic       dw_data_in,
  output logic       dw_data_in_valid,
  output logic       dw_rst_n,
  input  logic [7:0] dw_data_out,
  input  logic [1:0] dw_data_out_valid,
  input  logic       dw_fsc_end,
  output logic [7:0] byte_out,
  output logic [1:0] byte_kind,
  output logic       byte_ch,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       frame_abort,
  output logic [1:0] abort_cause,
  output logic       busy
);

  localparam int TO_W = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_RELEASE = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [9:0]      byte_cnt_q, byte_cnt_d;
  logic            ch0_gnt_q, ch0_gnt_d, ch1_gnt_q, ch1_gnt_d;
  logic            dw_rst_n_q, dw_rst_n_d;
  logic [7:0]      byte_out_q, byte_out_d;
  logic [1:0]      byte_kind_q, byte_kind_d;
  logic            byte_ch_q, byte_ch_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_abort_q, frame_abort_d;
  logic [1:0]      abort_cause_q, abort_cause_d;
  logic            own_bit, own_valid, feeding;

  // Zero-latency bit path from the owning channel into the dewhitener.
  always_comb begin
    own_bit          = owner_q ? ch1_bit : ch0_bit;
    own_valid        = owner_q ? ch1_bit_valid : ch0_bit_valid;
    feeding          = (state_q == S_GRANT) || (state_q == S_ACTIVE);
    dw_data_in       = feeding & own_bit;
    dw_data_in_valid = feeding & own_valid;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    to_cnt_d      = to_cnt_q;
    fl_cnt_d      = fl_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_out_d    = byte_out_q;
    byte_kind_d   = byte_kind_q;
    byte_ch_d     = byte_ch_q;
    byte_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    abort_cause_d = abort_cause_q;

    case (state_q)
      S_IDLE: begin
        if (ch0_req || ch1_req) begin
          state_d    = S_GRANT;
          owner_d    = (ch0_req && ch1_req) ? ~last_q : ch1_req;
          to_cnt_d   = '0;
          byte_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (own_valid) begin
          state_d = S_ACTIVE;
        end else if (to_cnt_q == TO_W'(START_TO - 1)) begin
          state_d       = S_FLUSH;
          fl_cnt_d      = '0;
          frame_abort_d = 1'b1;
          abort_cause_d = 2'd1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_ACTIVE: begin
        if (dw_data_out_valid != 2'd0) begin
          byte_valid_d = 1'b1;
          byte_out_d   = dw_data_out;
          byte_kind_d  = dw_data_out_valid;
          byte_ch_d    = owner_q;
          if (byte_cnt_q != 10'h3FF) byte_cnt_d = byte_cnt_q + 10'd1;
        end
        // End of frame wins over gap and length in the same cycle.
        if (dw_fsc_end) begin
          state_d      = S_RELEASE;
          frame_done_d = 1'b1;
        end else if (!own_valid) begin
          state_d       = S_FLUSH;
          fl_cnt_d      = '0;
          frame_abort_d = 1'b1;
          abort_cause_d = 2'd2;
        end else if (byte_cnt_q >= 10'(MAX_BYTES)) begin
          state_d       = S_FLUSH;
          fl_cnt_d      = '0;
          frame_abort_d = 1'b1;
          abort_cause_d = 2'd3;
        end
      end
      S_RELEASE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (fl_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          fl_cnt_d = fl_cnt_q + FL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ch0_gnt_d  = !owner_d && ((state_d == S_GRANT) || (state_d == S_ACTIVE));
    ch1_gnt_d  = owner_d && ((state_d == S_GRANT) || (state_d == S_ACTIVE));
    dw_rst_n_d = (state_d != S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      to_cnt_q      <= '0;
      fl_cnt_q      <= '0;
      byte_cnt_q    <= '0;
      ch0_gnt_q     <= 1'b0;
      ch1_gnt_q     <= 1'b0;
      dw_rst_n_q    <= 1'b0;
      byte_out_q    <= '0;
      byte_kind_q   <= '0;
      byte_ch_q     <= 1'b0;
      byte_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      abort_cause_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      to_cnt_q      <= to_cnt_d;
      fl_cnt_q      <= fl_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      ch0_gnt_q     <= ch0_gnt_d;
      ch1_gnt_q     <= ch1_gnt_d;
      dw_rst_n_q    <= dw_rst_n_d;
      byte_out_q    <= byte_out_d;
      byte_kind_q   <= byte_kind_d;
      byte_ch_q     <= byte_ch_d;
      byte_valid_q  <= byte_valid_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      abort_cause_q <= abort_cause_d;
    end
  end

  assign ch0_gnt     = ch0_gnt_q;
  assign ch1_gnt     = ch1_gnt_q;
  assign dw_rst_n    = dw_rst_n_q;
  assign byte_out    = byte_out_q;
  assign byte_kind   = byte_kind_q;
  assign byte_ch     = byte_ch_q;
  assign byte_valid  = byte_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign abort_cause = abort_cause_q;
  assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dewhiten_arbiter.sv
// ============================================================================
// Module  : tb_dewhiten_arbiter
// Purpose : Self-checking bench with a PN9 dewhitener model and byte scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dewhiten_arbiter;

  localparam int START_TO  = 64;
  localparam int MAX_BYTES = 5;
  localparam int FLUSH_CYC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ch0_req, ch1_req, ch0_bit, ch1_bit, ch0_bit_valid, ch1_bit_valid;
  logic       ch0_gnt, ch1_gnt, dw_data_in, dw_data_in_valid, dw_rst_n;
  logic [7:0] dw_data_out = '0;
  logic [1:0] dw_data_out_valid = '0;
  logic       dw_fsc_end = 1'b0;
  logic [7:0] byte_out;
  logic [1:0] byte_kind, abort_cause;
  logic       byte_ch, byte_valid, frame_done, frame_abort, busy;

  always #5 clk = ~clk;

  dewhiten_arbiter #(
    .START_TO (START_TO),
    .MAX_BYTES(MAX_BYTES),
    .FLUSH_CYC(FLUSH_CYC)
  ) u_dut (
    .clk(clk), .rst(rst),
    .ch0_req(ch0_req), .ch1_req(ch1_req),
    .ch0_bit(ch0_bit), .ch1_bit(ch1_bit),
    .ch0_bit_valid(ch0_bit_valid), .ch1_bit_valid(ch1_bit_valid),
    .ch0_gnt(ch0_gnt), .ch1_gnt(ch1_gnt),
    .dw_data_in(dw_data_in), .dw_data_in_valid(dw_data_in_valid), .dw_rst_n(dw_rst_n),
    .dw_data_out(dw_data_out), .dw_data_out_valid(dw_data_out_valid), .dw_fsc_end(dw_fsc_end),
    .byte_out(byte_out), .byte_kind(byte_kind), .byte_ch(byte_ch), .byte_valid(byte_valid),
    .frame_done(frame_done), .frame_abort(frame_abort), .abort_cause(abort_cause), .busy(busy)
  );

  // PN9 dewhitener model: reloads on reset or missing valid, frames by PHR length.
  logic [8:0] m_pn = 9'h1FF;
  logic [2:0] m_bc = '0;
  logic [7:0] m_sh = '0;
  int         m_nb = 0;
  int         m_total = 0;
  logic       m_d;
  logic [7:0] m_nxt;
  assign m_d   = dw_data_in ^ m_pn[0];
  assign m_nxt = {m_d, m_sh[7:1]};

  always @(posedge clk) begin
    dw_data_out_valid <= 2'd0;
    dw_fsc_end        <= 1'b0;
    if (!dw_rst_n || !dw_data_in_valid) begin
      m_pn    <= 9'h1FF;
      m_bc    <= '0;
      m_nb    <= 0;
      m_total <= 0;
    end else begin
      m_pn <= {m_pn[0] ^ m_pn[5], m_pn[8:1]};
      m_sh <= m_nxt;
      m_bc <= m_bc + 3'd1;
      if (m_bc == 3'd7) begin
        dw_data_out <= m_nxt;
        m_nb        <= m_nb + 1;
        if (m_nb == 0) begin
          dw_data_out_valid <= 2'd1;
          m_total           <= int'(m_nxt) + 2;
        end else if (m_nb == m_total - 1) begin
          dw_data_out_valid <= 2'd3;
          dw_fsc_end        <= 1'b1;
        end else begin
          dw_data_out_valid <= 2'd2;
        end
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;
  int          bv_cnt = 0;
  logic [10:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    logic [1:0]  fh;
    logic [10:0] e;
    fh = '0;
    forever begin
      @(negedge clk);
      if (fh[0]) begin
        chk("release_done_pulse", 32'(frame_done), 32'd1);
        chk("release_gnt_low", 32'(ch0_gnt | ch1_gnt), 32'd0);
        chk("release_dw_valid_low", 32'(dw_data_in_valid), 32'd0);
      end
      if (fh[1]) chk("idle_busy_low", 32'(busy), 32'd0);
      fh = {fh[0], dw_fsc_end};
      if (ch0_gnt && ch1_gnt) chk("dual_grant", 32'd1, 32'd0);
      if (byte_valid) begin
        bv_cnt++;
        if (sb.size() == 0) begin
          chk("byte_unexpected", {21'd0, byte_out, byte_kind, byte_ch}, 32'h7FF);
        end else begin
          e = sb.pop_front();
          chk("byte_fwd", {21'd0, byte_out, byte_kind, byte_ch}, {21'd0, e});
        end
      end
      if (frame_done)  done_cnt++;
      if (frame_abort) abort_cnt++;
    end
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (ch0_gnt || ch1_gnt) ok = 1'b1;
    end
  endtask

  task automatic wait_end(input int base);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (done_cnt + abort_cnt != base) ok = 1'b1;
    end
    chk("frame_end_timeout", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Whitens and serialises PHR/payload/tail; stops when the grant goes away.
  task automatic send_frame(input logic ch, input int plen, input int gap_at, input int rst_at);
    logic [7:0] fb[$];
    logic [8:0] pn;
    logic [7:0] cur;
    logic [1:0] kind;
    logic       b;
    int         n;
    fb.push_back(8'(plen));
    for (int i = 0; i < plen; i++) fb.push_back(8'(60 + 37 * i + 5 * int'(ch)));
    fb.push_back(8'hC3);
    pn = 9'h1FF;
    n  = fb.size() * 8;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && !(ch ? ch1_gnt : ch0_gnt)) break;
      if (i == rst_at) begin
        rst = 1'b1;
        ch0_bit_valid = 1'b0; ch1_bit_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (i == gap_at) begin
        if (ch) ch1_bit_valid = 1'b0; else ch0_bit_valid = 1'b0;
        @(posedge clk); #1;
        break;
      end
      cur = fb[i / 8];
      b   = cur[i % 8] ^ pn[0];
      pn  = {pn[0] ^ pn[5], pn[8:1]};
      if (ch) begin
        ch1_bit = b; ch1_bit_valid = 1'b1;
        ch0_bit = 1'($urandom); ch0_bit_valid = 1'($urandom);
      end else begin
        ch0_bit = b; ch0_bit_valid = 1'b1;
        ch1_bit = 1'($urandom); ch1_bit_valid = 1'($urandom);
      end
      if (i % 8 == 7) begin
        kind = (i / 8 == 0) ? 2'd1 : ((i / 8 == fb.size() - 1) ? 2'd3 : 2'd2);
        sb.push_back({cur, kind, ch});
      end
      @(posedge clk); #1;
    end
    ch0_bit = 1'b0; ch0_bit_valid = 1'b0;
    ch1_bit = 1'b0; ch1_bit_valid = 1'b0;
  endtask

  typedef struct {
    logic req0;
    logic req1;
    logic ch;
    int   plen;
    int   gap;
    logic ab;
    int   cause;
    int   nbytes;
  } vec_t;

  vec_t vec[6];

  initial begin
    logic ok;
    int   d0, a0, b0, n;

    vec[0] = '{1'b1, 1'b1, 1'b0, 3,  -1, 1'b0, 0, 5};
    vec[1] = '{1'b0, 1'b1, 1'b1, 1,  -1, 1'b0, 0, 3};
    vec[2] = '{1'b1, 1'b1, 1'b0, 3,  20, 1'b1, 2, 2};
    vec[3] = '{1'b0, 1'b1, 1'b1, 0,  -1, 1'b0, 0, 2};
    vec[4] = '{1'b1, 1'b1, 1'b0, 10, -1, 1'b1, 3, 5};
    vec[5] = '{1'b0, 1'b1, 1'b1, 2,  -1, 1'b0, 0, 4};

    rst = 1'b1;
    ch0_req = 1'b0; ch1_req = 1'b0;
    ch0_bit = 1'b0; ch1_bit = 1'b0; ch0_bit_valid = 1'b0; ch1_bit_valid = 1'b0;
    fork
      mon();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", {30'd0, ch1_gnt, ch0_gnt}, 32'd0);
    chk("reset_dw_rst_n", 32'(dw_rst_n), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", {28'd0, byte_valid, frame_done, frame_abort, dw_data_in_valid}, 32'd0);
    chk("reset_cause", 32'(abort_cause), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_dw_rst_n", 32'(dw_rst_n), 32'd1);

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt; a0 = abort_cnt; b0 = bv_cnt;
      if (vec[v].req0) ch0_req = 1'b1;
      if (vec[v].req1) ch1_req = 1'b1;
      wait_gnt(ok);
      chk($sformatf("v%0d_grant_timeout", v), 32'(ok), 32'd1);
      chk($sformatf("v%0d_grant_owner", v), {30'd0, ch1_gnt, ch0_gnt},
          vec[v].ch ? 32'd2 : 32'd1);
      if (vec[v].ch) ch1_req = 1'b0; else ch0_req = 1'b0;
      send_frame(vec[v].ch, vec[v].plen, vec[v].gap, -1);
      wait_end(d0 + a0);
      chk($sformatf("v%0d_done_count", v), 32'(done_cnt - d0), vec[v].ab ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_abort_count", v), 32'(abort_cnt - a0), vec[v].ab ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_byte_count", v), 32'(bv_cnt - b0), 32'(vec[v].nbytes));
      if (vec[v].ab) chk($sformatf("v%0d_abort_cause", v), 32'(abort_cause), 32'(vec[v].cause));
      chk($sformatf("v%0d_sb_empty", v), 32'(sb.size()), 32'd0);
    end

    // Start timeout on ch1: no bit_valid after the grant.
    ch1_req = 1'b1;
    wait_gnt(ok);
    chk("to_grant_ch1", {30'd0, ch1_gnt, ch0_gnt}, 32'd2);
    ch1_req = 1'b0;
    n = 0;
    while (!frame_abort && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(START_TO));
    chk("to_cause", 32'(abort_cause), 32'd1);
    chk("to_gnt_low", 32'(ch1_gnt), 32'd0);
    n = 0;
    while (!dw_rst_n && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("to_flush_len", 32'(n), 32'(FLUSH_CYC));

    // Reset in the middle of a ch0 payload.
    repeat (3) @(negedge clk);
    ch0_req = 1'b1;
    wait_gnt(ok);
    chk("rst_grant_ch0", {30'd0, ch1_gnt, ch0_gnt}, 32'd1);
    ch0_req = 1'b0;
    d0 = done_cnt; a0 = abort_cnt;
    send_frame(1'b0, 10, -1, 28);
    chk("midrst_gnt", {30'd0, ch1_gnt, ch0_gnt}, 32'd0);
    chk("midrst_flags", {28'd0, byte_valid, frame_done, frame_abort, busy}, 32'd0);
    chk("midrst_cause", 32'(abort_cause), 32'd0);
    chk("midrst_dw", {30'd0, dw_rst_n, dw_data_in_valid}, 32'd0);
    chk("midrst_byte", {21'd0, byte_out, byte_kind, byte_ch}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_pulses", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

    d0 = done_cnt; a0 = abort_cnt; b0 = bv_cnt;
    ch1_req = 1'b1;
    wait_gnt(ok);
    chk("after_rst_grant_ch1", {30'd0, ch1_gnt, ch0_gnt}, 32'd2);
    ch1_req = 1'b0;
    send_frame(1'b1, 3, -1, -1);
    wait_end(d0 + a0);
    chk("after_rst_done", 32'(done_cnt - d0), 32'd1);
    chk("after_rst_bytes", 32'(bv_cnt - b0), 32'd5);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
